// File: rtl/ecc_secded_engine.sv
// ecc_secded_engine: APB-programmed SECDED encode/decode/full-channel engine for N = 8/16/32.
module ecc_secded_engine #(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       operation_done,
  output logic [1:0]                 num_of_errors
);
  typedef enum logic [1:0] {IDLE, ENC, NOISE, DEC} state_t;
  state_t state_q, state_d;
  logic [1:0]  ctrl_q, width_q, mode_w, n_w;
  logic [31:0] data_q, noise_q, cw_w, noise_w, enc_c, rdata;
  logic [33:0] dec_c;
  logic        overrun_q, cfg_err_q, wr, rd_setup, st_clr, ctrl_wr, busy, cfg_bad, start, done_c;
  logic [2:0]  idx;
  int          n_bits;
  logic        unused_addr;
  function automatic logic [31:0] low_mask(input int n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction
  function automatic logic [31:0] enc(input logic [31:0] d, input int n);
    logic [31:0] c;
    logic [4:0]  k;
    logic        p;
    c = '0;
    k = '0;
    for (int i = 0; i < 31; i++)
      if (i < n - 1 && ((i + 1) & i) != 0) begin
        c[i] = d[k];
        k = k + 5'd1;
      end
    for (int j = 0; j < 5; j++)
      if ((1 << j) < n) begin
        p = 1'b0;
        for (int i = 0; i < 31; i++)
          if (i < n - 1 && (((i + 1) >> j) & 1) == 1) p = p ^ c[i];
        c[(1 << j) - 1] = p;
      end
    c[n - 1] = ^(c & low_mask(n - 1));
    return c;
  endfunction
  // Returns {num_of_errors, corrected data}.
  function automatic logic [33:0] dec(input logic [31:0] c_in, input int n);
    logic [31:0] c, d;
    logic [4:0]  s, k;
    logic        q;
    c = c_in & low_mask(n);
    s = '0;
    for (int i = 0; i < 31; i++)
      if (i < n - 1 && c[i]) s = s ^ 5'(i + 1);
    q = ^c;
    if (q && s != 5'd0) c[s - 5'd1] = ~c[s - 5'd1];
    d = '0;
    k = '0;
    for (int i = 0; i < 31; i++)
      if (i < n - 1 && ((i + 1) & i) != 0) begin
        d[k] = c[i];
        k = k + 5'd1;
      end
    return {q ? 2'd1 : (s != 5'd0 ? 2'd2 : 2'd0), d};
  endfunction
  assign unused_addr = ^{PADDR[AMBA_ADDR_WIDTH-1:5], PADDR[1:0]};
  assign idx      = PADDR[4:2];
  assign wr       = PSEL & PENABLE & PWRITE;
  assign rd_setup = PSEL & ~PENABLE & ~PWRITE;
  assign st_clr   = PSEL & PENABLE & ~PWRITE & (idx == 3'd4);
  assign ctrl_wr  = wr & (idx == 3'd0);
  assign busy     = state_q != IDLE;
  assign cfg_bad  = (PWDATA[1:0] == 2'd3) | (width_q == 2'd3);
  assign start    = ctrl_wr & ~busy & ~cfg_bad;
  assign done_c   = (state_q == ENC && mode_w == 2'd0) || state_q == DEC;
  assign n_bits   = (n_w == 2'd0) ? 8 : (n_w == 2'd1) ? 16 : 32;
  assign enc_c    = enc(cw_w, n_bits);
  assign dec_c    = dec(cw_w, n_bits);
  assign rdata = (idx == 3'd0) ? {30'd0, ctrl_q} :
                 (idx == 3'd1) ? data_q :
                 (idx == 3'd2) ? {30'd0, width_q} :
                 (idx == 3'd3) ? noise_q :
                 (idx == 3'd4) ? {27'd0, cfg_err_q, overrun_q, num_of_errors, busy} : 32'd0;
  always_comb begin
    state_d = (state_q == IDLE)  ? (start ? (PWDATA[0] ? DEC : ENC) : IDLE) :
              (state_q == ENC)   ? (mode_w[1] ? NOISE : IDLE) :
              (state_q == NOISE) ? DEC : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      ctrl_q         <= '0;
      width_q        <= '0;
      data_q         <= '0;
      noise_q        <= '0;
      mode_w         <= '0;
      n_w            <= '0;
      cw_w           <= '0;
      noise_w        <= '0;
      overrun_q      <= 1'b0;
      cfg_err_q      <= 1'b0;
      PRDATA         <= '0;
      data_out       <= '0;
      num_of_errors  <= '0;
      operation_done <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ctrl_wr && !busy) ctrl_q <= PWDATA[1:0];
      if (wr && idx == 3'd1) data_q <= PWDATA[31:0];
      if (wr && idx == 3'd2) width_q <= PWDATA[1:0];
      if (wr && idx == 3'd3) noise_q <= PWDATA[31:0];
      if (rd_setup) PRDATA <= AMBA_WORD'(rdata);
      overrun_q      <= (ctrl_wr & busy) | (overrun_q & ~st_clr);
      cfg_err_q      <= (ctrl_wr & ~busy & cfg_bad) | (cfg_err_q & ~st_clr);
      operation_done <= done_c;
      if (start) begin
        mode_w  <= PWDATA[1:0];
        n_w     <= width_q;
        cw_w    <= data_q;
        noise_w <= noise_q;
      end else if (state_q == ENC) cw_w <= enc_c;
      else if (state_q == NOISE) cw_w <= cw_w ^ noise_w;
      if (done_c) begin
        data_out      <= DATA_WIDTH'(state_q == DEC ? dec_c[31:0] : enc_c);
        num_of_errors <= (state_q == DEC) ? dec_c[33:32] : 2'd0;
      end
    end
  end
endmodule

// File: tb/tb_ecc_secded_engine.sv
// tb_ecc_secded_engine: scoreboard bench with a brute-force SECDED reference model.
module tb_ecc_secded_engine;
  logic        clk = 0, rst = 0;
  logic [19:0] PADDR = '0;
  logic [31:0] PWDATA = '0, PRDATA, data_out;
  logic        PSEL = 0, PENABLE = 0, PWRITE = 0, operation_done;
  logic [1:0]  num_of_errors;
  int errors = 0, checks = 0, cyc = 0;
  typedef struct {logic [31:0] d; logic [1:0] e; int due;} exp_t;
  exp_t sb[$];
  ecc_secded_engine dut (
    .clk(clk), .rst(rst), .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PRDATA(PRDATA), .data_out(data_out), .operation_done(operation_done),
    .num_of_errors(num_of_errors)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (operation_done) begin
      exp_t x;
      if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        x = sb.pop_front();
        chk("data_out", data_out, x.d);
        chk("num_of_errors", {30'd0, num_of_errors}, {30'd0, x.e});
        chk("done_latency", cyc, x.due);
      end
    end
  function automatic int nsel(input logic [1:0] w);
    return w == 2'd0 ? 8 : w == 2'd1 ? 16 : 32;
  endfunction
  // Parity bits chosen so the XOR of the positions of all set bits is zero.
  function automatic logic [31:0] ref_enc(input logic [31:0] d, input int n);
    logic [31:0] c = '0;
    int k = 0, x = 0;
    for (int p = 1; p < n; p++)
      if ((p & (p - 1)) != 0) begin c[p-1] = d[k]; k++; end
    for (int p = 1; p < n; p++) if (c[p-1]) x ^= p;
    for (int j = 0; (1 << j) < n; j++) if (x[j]) c[(1 << j) - 1] = 1'b1;
    c[n-1] = ^c;
    return c;
  endfunction
  function automatic logic [31:0] ref_ext(input logic [31:0] c, input int n);
    logic [31:0] d = '0;
    int k = 0;
    for (int p = 1; p < n; p++)
      if ((p & (p - 1)) != 0) begin d[k] = c[p-1]; k++; end
    return d;
  endfunction
  function automatic logic [33:0] ref_dec(input logic [31:0] cin, input int n);
    logic [31:0] c, c2, m;
    m = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 1);
    c = cin & m;
    if (ref_enc(ref_ext(c, n), n) == c) return {2'd0, ref_ext(c, n)};
    for (int b = 0; b < n; b++) begin
      c2 = c ^ (32'd1 << b);
      if (ref_enc(ref_ext(c2, n), n) == c2) return {2'd1, ref_ext(c2, n)};
    end
    return {2'd2, ref_ext(c, n)};
  endfunction
  task automatic apb_wr(input logic [2:0] idx, input logic [31:0] d);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = {15'd0, idx, 2'b00}; PWDATA = d;
    @(negedge clk) PENABLE = 1;
    @(negedge clk) begin PSEL = 0; PENABLE = 0; PWRITE = 0; end
  endtask
  task automatic apb_rd(input logic [2:0] idx, output logic [31:0] d);
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = {15'd0, idx, 2'b00};
    @(negedge clk) begin PENABLE = 1; d = PRDATA; end
    @(negedge clk) begin PSEL = 0; PENABLE = 0; end
  endtask
  task automatic op(input logic [1:0] m, input logic [1:0] w, input logic [31:0] din,
                    input logic [31:0] nz, input logic [31:0] ed, input logic [1:0] ee);
    apb_wr(3'd2, {30'd0, w});
    apb_wr(3'd1, din);
    apb_wr(3'd3, nz);
    apb_wr(3'd0, {30'd0, m});
    sb.push_back('{ed, ee, cyc + (m == 2'd2 ? 3 : 1)});
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("done_timeout", 32'd1, 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask
  task automatic rd_chk(input string name, input logic [2:0] idx, input logic [31:0] exp);
    logic [31:0] r;
    apb_rd(idx, r);
    chk(name, r, exp);
  endtask
  initial begin
    logic [31:0] r, din, nz, ed;
    logic [33:0] md;
    logic [1:0]  m, w;
    int n;
    repeat (2) @(negedge clk);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_errs", {30'd0, num_of_errors}, 32'd0);
    chk("rst_done", {31'd0, operation_done}, 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    rst = 1;
    @(negedge clk);
    rd_chk("rst_status", 3'd4, 32'd0);
    op(2'd0, 2'd0, 32'hB, 32'd0, 32'h55, 2'd0); wait_idle();
    rd_chk("data_in_readback", 3'd1, 32'hB);
    op(2'd2, 2'd0, 32'hB, 32'h04, 32'hB, 2'd1); wait_idle();
    op(2'd2, 2'd0, 32'hB, 32'h80, 32'hB, 2'd1); wait_idle();
    op(2'd2, 2'd0, 32'hB, 32'h06, 32'hA, 2'd2); wait_idle();
    rd_chk("status_err2", 3'd4, 32'h04);
    op(2'd1, 2'd2, 32'd0, 32'd0, 32'd0, 2'd0); wait_idle();
    op(2'd0, 2'd2, 32'h3FF_FFFF, 32'd0, ref_enc(32'h3FF_FFFF, 32), 2'd0); wait_idle();
    op(2'd2, 2'd0, 32'hB, 32'd0, 32'hB, 2'd0);
    apb_wr(3'd0, 32'd0);
    rd_chk("status_busy_overrun", 3'd4, 32'h09);
    wait_idle();
    rd_chk("status_overrun_cleared", 3'd4, 32'h00);
    apb_wr(3'd0, 32'd3);
    rd_chk("cfg_err_mode", 3'd4, 32'h10);
    rd_chk("cfg_err_cleared", 3'd4, 32'h00);
    apb_wr(3'd2, 32'd3);
    apb_wr(3'd0, 32'd0);
    rd_chk("cfg_err_width", 3'd4, 32'h10);
    apb_wr(3'd2, 32'd0);
    repeat (6) @(negedge clk);
    op(2'd2, 2'd0, 32'hB, 32'h04, 32'hB, 2'd1);
    @(negedge clk);
    rst = 0;
    sb.delete();
    #1;
    chk("abort_data_out", data_out, 32'd0);
    chk("abort_errs", {30'd0, num_of_errors}, 32'd0);
    chk("abort_done", {31'd0, operation_done}, 32'd0);
    chk("abort_prdata", PRDATA, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (6) @(negedge clk);
    rd_chk("abort_status", 3'd4, 32'd0);
    op(2'd0, 2'd0, 32'h5, 32'd0, ref_enc(32'h5, 8), 2'd0); wait_idle();
    for (int t = 0; t < 60; t++) begin
      m = 2'($urandom_range(2));
      w = 2'($urandom_range(2));
      n = nsel(w);
      din = $urandom;
      case ($urandom_range(3))
        0: nz = 32'd0;
        1: nz = 32'd1 << $urandom_range(n - 1);
        2: nz = (32'd1 << $urandom_range(n - 1)) ^ (32'd1 << $urandom_range(n - 1));
        default: nz = $urandom;
      endcase
      if (m == 2'd0) begin
        ed = ref_enc(din, n);
        md = {2'd0, ed};
      end else if (m == 2'd1) md = ref_dec(din, n);
      else md = ref_dec(ref_enc(din, n) ^ nz, n);
      op(m, w, din, nz, md[31:0], md[33:32]);
      wait_idle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
